// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants and state encoding for pipe_stage_buf and its slot register.
// PIPE_STAGE_SKID_EN selects the two-slot skid build in the files that import this package.
package pipe_stage_buf_pkg;

    localparam int          DefaultAddrW = 32;
    localparam int          DefaultDataW = 32;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        RstnEnable   = 1'b0;

    // The non-skid build reuses ST_ONE as its FULL state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_stage_buf_slot.sv
// pipe_slot: one PC/instruction register with synchronous load and clear.
// Reset and clear both force the word to zero, so an empty slot always reads as a bubble.
module pipe_slot
    import pipe_stage_buf_pkg::*;
#(
    parameter int W = DefaultAddrW + DefaultDataW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    logic [W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst == RstnEnable || i_clear) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready buffer carrying a PC/instruction pair between two pipeline stages.
// Define PIPE_STAGE_SKID_EN for the two-slot skid buffer; otherwise a single slot is built.
//
// Handshake: a word moves on a rising edge when valid and ready are both high on that
// side; valid never waits for ready, and the offered word must stay stable until taken.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int ADDR_W = DefaultAddrW,
    parameter int DATA_W = DefaultDataW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_inst,
    output logic [1:0]        dbg_state
);

    localparam int W = ADDR_W + DATA_W;

    state_e       r_state;
    logic         r_out_valid;
    logic         w_accept;
    logic         w_pop;
    logic         w_main_load;
    logic         w_main_clear;
    logic [W-1:0] w_main_d;
    logic [W-1:0] w_main_q;

    assign w_accept  = in_valid & in_ready;
    assign w_pop     = r_out_valid & out_ready;
    assign out_valid = r_out_valid;
    assign dbg_state = r_state;

`ifdef PIPE_STAGE_SKID_EN

    logic         r_has_room;
    logic         w_skid_load;
    logic         w_skid_clear;
    logic [W-1:0] w_skid_q;

    // Registered room flag keeps out_ready out of the in_ready cone.
    assign in_ready = r_has_room & ~flush;

    always_ff @(posedge clk) begin
        if (rst == RstnEnable || flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_has_room  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_pop) begin
                        r_state    <= ST_TWO;
                        r_has_room <= 1'b0;
                    end else if (!w_accept && w_pop) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        r_state    <= ST_ONE;
                        r_has_room <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_has_room  <= 1'b1;
                end
            endcase
        end
    end

    assign w_main_load  = ((r_state == ST_EMPTY) && w_accept)
                        | ((r_state == ST_ONE) && w_accept && w_pop)
                        | ((r_state == ST_TWO) && w_pop);
    assign w_main_clear = flush | ((r_state == ST_ONE) && !w_accept && w_pop);
    assign w_main_d     = (r_state == ST_TWO) ? w_skid_q : {in_pc, in_inst};

    assign w_skid_load  = (r_state == ST_ONE) && w_accept && !w_pop;
    assign w_skid_clear = flush | ((r_state == ST_TWO) && w_pop);

    pipe_slot #(
        .W (W)
    ) u_skid_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  ({in_pc, in_inst}),
        .o_data  (w_skid_q)
    );

`else

    // Single slot: a word may enter in the same cycle the consumer drains the old one.
    assign in_ready = (~r_out_valid | out_ready) & ~flush;

    always_ff @(posedge clk) begin
        if (rst == RstnEnable || flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_pop && !w_accept) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign w_main_load  = w_accept;
    assign w_main_clear = flush | (w_pop && !w_accept);
    assign w_main_d     = {in_pc, in_inst};

`endif

    pipe_slot #(
        .W (W)
    ) u_main_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_d),
        .o_data  (w_main_q)
    );

    assign out_pc   = w_main_q[W-1:DATA_W];
    assign out_inst = w_main_q[DATA_W-1:0];

endmodule
